// File: rtl/ddr_port_pkg.sv
// Shared definitions for the MCB port readers/writers of the frame buffer.
// Holds the MCB command encodings, the port-1 reader state encoding and the
// default frame geometry shared with the port-0 frame writer.
package ddr_port_pkg;

  localparam logic [2:0] INSTR_WRITE = 3'b000;
  localparam logic [2:0] INSTR_READ  = 3'b001;

  typedef enum logic [2:0] {
    S_CALIB,
    S_IDLE,
    S_CMD,
    S_XFER,
    S_DONE
  } rd_state_e;

  // 640x480 frame of 32-bit pixels, two buffers back to back in DDR.
  localparam int FRAME_PIX_W     = 640;
  localparam int FRAME_PIX_H     = 480;
  localparam int VGA_FRAME_WORDS = FRAME_PIX_W * FRAME_PIX_H;
  localparam int MCB_BURST_LEN   = 32;
  localparam int BUF0_BASE_ADDR  = 0;
  localparam int BUF1_BASE_ADDR  = VGA_FRAME_WORDS * 4;

endpackage

// File: rtl/pixel_prefetch_fifo.sv
// First-word-fall-through prefetch FIFO between the MCB read port and the
// pixel stream. Writes pass through an input register, then RAM, then an
// output head register, so a written word is visible on data_o three cycles
// after the write strobe.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   flush_i     - drop all stored words (write on the same cycle is ignored)
//   wr_en_i     - write wr_data_i
//   rd_en_i     - consume the head word (ignored when valid_o is low)
//   valid_o     - data_o holds the head word
//   free_o      - entries free, counting words still in the input register
module pixel_prefetch_fifo #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]  free_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              in_vld_q;
  logic [DATA_W-1:0] in_data_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
  logic              head_vld_q;
  logic [DATA_W-1:0] head_q;
  logic              pop_head, mem_rd;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign pop_head  = rd_en_i && head_vld_q;
  assign mem_rd    = (mem_cnt_q != '0) && (!head_vld_q || pop_head);
  assign mem_cnt_d = mem_cnt_q + CNT_W'(in_vld_q) - CNT_W'(mem_rd);

  assign valid_o = head_vld_q;
  assign data_o  = head_q;
  assign free_o  = CNT_W'(DEPTH) - (mem_cnt_q + CNT_W'(in_vld_q) + CNT_W'(head_vld_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
    end else if (flush_i) begin
      in_vld_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      head_vld_q <= 1'b0;
    end else begin
      in_vld_q  <= wr_en_i;
      mem_cnt_q <= mem_cnt_d;
      if (in_vld_q) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (mem_rd)   rd_ptr_q <= next_ptr(rd_ptr_q);
      if (mem_rd)        head_vld_q <= 1'b1;
      else if (pop_head) head_vld_q <= 1'b0;
    end
  end

  // input register -> RAM -> head register
  always_ff @(posedge clk) begin
    in_data_q <= wr_data_i;
    if (in_vld_q) mem_q[wr_ptr_q] <= in_data_q;
    if (mem_rd)   head_q <= mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/ddr_port1_reader.sv
// Frame reader on MCB user port 1. Issues fixed-length read bursts for the
// selected frame buffer, pops the MCB read FIFO into a local prefetch FIFO
// and streams the words to scanout on a valid/ready interface.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   mem_calib_done        - MCB calibration done (asynchronous input)
//   p1_cmd_*              - MCB command port (read bursts only)
//   p1_rd_*               - MCB read data FIFO
//   frame_start/buffer_sel- start fetching frame buffer buffer_sel
//   pix_*                 - pixel stream, pix_last marks the final word
//   frame_busy            - fetch in progress
//   underrun              - sticky: consumer found no data mid-frame
module ddr_port1_reader
  import ddr_port_pkg::*;
#(
  parameter int BURST_LEN   = MCB_BURST_LEN,
  parameter int FRAME_WORDS = VGA_FRAME_WORDS,
  parameter int BUF0_BASE   = BUF0_BASE_ADDR,
  parameter int BUF1_BASE   = BUF1_BASE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_calib_done,
  input  logic        p1_cmd_full,
  input  logic        p1_rd_empty,
  input  logic [31:0] p1_rd_data,
  output logic        p1_cmd_en,
  output logic [2:0]  p1_cmd_instr,
  output logic [5:0]  p1_cmd_bl,
  output logic [29:0] p1_cmd_byte_addr,
  output logic        p1_rd_en,
  input  logic        frame_start,
  input  logic        buffer_sel,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [31:0] pix_data,
  output logic        pix_last,
  output logic        frame_busy,
  output logic        underrun
);

  localparam int IDX_W  = $clog2(FRAME_WORDS + 1);
  localparam int DEPTH  = 2 * BURST_LEN;
  localparam int FREE_W = $clog2(DEPTH + 1);
  localparam int BC_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic             calib_meta_q, calib_sync_q;
  rd_state_e        state_q, state_d;
  logic [29:0]      base_q, base_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic             busy_q, busy_d;
  logic             underrun_q, underrun_d;
  logic             restart_q, restart_d;
  logic             restart_sel_q, restart_sel_d;

  logic [FREE_W-1:0] fifo_free;
  logic              fifo_valid, fifo_wr, flush;
  logic [31:0]       fifo_data;
  logic              pop, burst_end, last_burst, issue;
  logic              start_now, restart_now, start_sel, xfer_out, frame_done;

  assign pop         = (state_q == S_XFER) && !p1_rd_empty;
  assign burst_end   = pop && (burst_cnt_q == BC_W'(BURST_LEN - 1));
  assign last_burst  = (word_idx_q + IDX_W'(BURST_LEN)) == IDX_W'(FRAME_WORDS);
  // A start outside S_XFER has no burst in flight, so it takes effect at once.
  assign start_now   = frame_start &&
                       ((state_q == S_IDLE) || (state_q == S_CMD) || (state_q == S_DONE));
  assign restart_now = burst_end && (restart_q || frame_start);
  assign start_sel   = frame_start ? buffer_sel : restart_sel_q;
  assign issue       = (state_q == S_CMD) && !frame_start && !p1_cmd_full &&
                       (fifo_free >= FREE_W'(BURST_LEN));
  // Words of a burst that is being abandoned are popped but not kept.
  assign fifo_wr     = pop && !restart_q && !frame_start;
  assign flush       = start_now || restart_now;
  assign xfer_out    = fifo_valid && pix_ready;
  assign frame_done  = (state_q == S_DONE) && xfer_out && pix_last;

  assign pix_valid    = fifo_valid;
  assign pix_data     = fifo_data;
  assign pix_last     = fifo_valid && (out_idx_q == IDX_W'(FRAME_WORDS - 1));
  assign frame_busy   = busy_q;
  assign underrun     = underrun_q;
  assign p1_cmd_instr = INSTR_READ;
  assign p1_cmd_bl    = 6'(BURST_LEN - 1);

  pixel_prefetch_fifo #(.DEPTH(DEPTH), .DATA_W(32)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .wr_en_i  (fifo_wr),
    .wr_data_i(p1_rd_data),
    .rd_en_i  (xfer_out),
    .valid_o  (fifo_valid),
    .data_o   (fifo_data),
    .free_o   (fifo_free)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      calib_meta_q  <= 1'b0;
      calib_sync_q  <= 1'b0;
      state_q       <= S_CALIB;
      base_q        <= '0;
      word_idx_q    <= '0;
      out_idx_q     <= '0;
      burst_cnt_q   <= '0;
      busy_q        <= 1'b0;
      underrun_q    <= 1'b0;
      restart_q     <= 1'b0;
      restart_sel_q <= 1'b0;
    end else begin
      calib_meta_q  <= mem_calib_done;
      calib_sync_q  <= calib_meta_q;
      state_q       <= state_d;
      base_q        <= base_d;
      word_idx_q    <= word_idx_d;
      out_idx_q     <= out_idx_d;
      burst_cnt_q   <= burst_cnt_d;
      busy_q        <= busy_d;
      underrun_q    <= underrun_d;
      restart_q     <= restart_d;
      restart_sel_q <= restart_sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CALIB: if (calib_sync_q) state_d = S_IDLE;
      S_IDLE:  if (start_now) state_d = S_CMD;
      S_CMD:   if (!start_now && issue) state_d = S_XFER;
      S_XFER:  if (burst_end) state_d = (!restart_now && last_burst) ? S_DONE : S_CMD;
      S_DONE:  if (start_now) state_d = S_CMD;
               else if (frame_done) state_d = S_IDLE;
      default: state_d = S_CALIB;
    endcase
  end

  always_comb begin
    p1_cmd_en        = issue;
    p1_rd_en         = pop;
    p1_cmd_byte_addr = issue ? base_q + (30'(word_idx_q) << 2) : '0;
  end

  always_comb begin
    base_d        = base_q;
    word_idx_d    = word_idx_q;
    out_idx_d     = out_idx_q;
    burst_cnt_d   = burst_cnt_q;
    busy_d        = busy_q;
    underrun_d    = underrun_q;
    restart_d     = restart_q;
    restart_sel_d = restart_sel_q;
    if (flush) begin
      base_d      = start_sel ? 30'(BUF1_BASE) : 30'(BUF0_BASE);
      word_idx_d  = '0;
      out_idx_d   = '0;
      burst_cnt_d = '0;
      busy_d      = 1'b1;
      underrun_d  = 1'b0;
      restart_d   = 1'b0;
    end else begin
      if (burst_end) begin
        burst_cnt_d = '0;
        word_idx_d  = word_idx_q + IDX_W'(BURST_LEN);
      end else if (pop) begin
        burst_cnt_d = burst_cnt_q + BC_W'(1);
      end
      if ((state_q == S_XFER) && frame_start) begin
        restart_d     = 1'b1;
        restart_sel_d = buffer_sel;
      end
      if (xfer_out)   out_idx_d = out_idx_q + IDX_W'(1);
      if (frame_done) busy_d = 1'b0;
      if (busy_q && pix_ready && !fifo_valid && (out_idx_q != '0)) underrun_d = 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port1_reader.sv
module tb_ddr_port1_reader;

  localparam int BL = 4;
  localparam int FW = 8;
  localparam int B0 = 0;
  localparam int B1 = 1024;

  logic        clk = 1'b0;
  logic        reset, mem_calib_done, p1_cmd_full, p1_rd_empty;
  logic [31:0] p1_rd_data;
  logic        p1_cmd_en, p1_rd_en;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        frame_start, buffer_sel, pix_ready;
  logic        pix_valid, pix_last, frame_busy, underrun;
  logic [31:0] pix_data;

  ddr_port1_reader #(.BURST_LEN(BL), .FRAME_WORDS(FW), .BUF0_BASE(B0), .BUF1_BASE(B1)) dut (
    .clk(clk), .reset(reset), .mem_calib_done(mem_calib_done),
    .p1_cmd_full(p1_cmd_full), .p1_rd_empty(p1_rd_empty), .p1_rd_data(p1_rd_data),
    .p1_cmd_en(p1_cmd_en), .p1_cmd_instr(p1_cmd_instr), .p1_cmd_bl(p1_cmd_bl),
    .p1_cmd_byte_addr(p1_cmd_byte_addr), .p1_rd_en(p1_rd_en),
    .frame_start(frame_start), .buffer_sel(buffer_sel), .pix_ready(pix_ready),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_last(pix_last),
    .frame_busy(frame_busy), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [31:0] mq_data[$];
  int          mq_rdy[$];
  int unsigned cmd_log[$];
  logic [31:0] out_data[$];
  bit          out_last[$];
  int pops, first_pop, first_vld;
  int dly1 = 0;
  int dly2 = 0;
  bit rnd = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: observe at the falling edge, update the MCB model after the rising edge.
  task automatic tick();
    bit pop_s, cmd_s;
    int unsigned addr_s;
    int d;
    @(negedge clk);
    pop_s  = p1_rd_en && !p1_rd_empty;
    cmd_s  = p1_cmd_en;
    addr_s = {2'b00, p1_cmd_byte_addr};
    if (p1_rd_en) chk_eq("rd_en_on_empty", 32'(p1_rd_empty), 0);
    if (cmd_s) begin
      chk_eq("cmd_bl", 32'(p1_cmd_bl), BL - 1);
      chk_eq("cmd_instr", 32'(p1_cmd_instr), 1);
      cmd_log.push_back(addr_s);
    end
    if (pop_s) begin
      pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    if (pix_valid && first_vld < 0) first_vld = cyc;
    if (pix_valid && pix_ready) begin
      out_data.push_back(pix_data);
      out_last.push_back(pix_last);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop_s && mq_data.size() > 0) begin
      mq_data.delete(0);
      mq_rdy.delete(0);
    end
    if (cmd_s) begin
      d = rnd ? int'($urandom_range(0, 5)) : ((cmd_log.size() == 2) ? dly2 : dly1);
      for (int i = 0; i < BL; i++) begin
        mq_data.push_back(addr_s + 32'(4 * i));
        mq_rdy.push_back(cyc + d);
      end
    end
    p1_rd_empty = !(mq_data.size() > 0 && mq_rdy[0] <= cyc);
    p1_rd_data  = (mq_data.size() > 0) ? mq_data[0] : 32'd0;
  endtask

  task automatic pulse_start(input bit sel);
    buffer_sel  = sel;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    buffer_sel  = 1'($urandom_range(0, 1));
  endtask

  task automatic start_frame(input bit sel);
    cmd_log.delete();
    out_data.delete();
    out_last.delete();
    pops = 0;
    first_pop = -1;
    first_vld = -1;
    pulse_start(sel);
  endtask

  task automatic run_until_idle(input string tag);
    int n = 0;
    while (frame_busy && n < 500) begin
      pix_ready = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
      if (rnd) p1_cmd_full = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    p1_cmd_full = 1'b0;
    chk_eq({tag, ":busy_fell"}, 32'(frame_busy), 0);
    chk_eq({tag, ":fifo_empty"}, 32'(pix_valid), 0);
  endtask

  // Expected frame: commands at base + 16*k, words base + 4*i, last on word FW-1.
  task automatic check_frame(input string tag, input int unsigned base, input int off);
    chk_eq({tag, ":ncmd"}, 32'(cmd_log.size()), 32'(FW / BL + off));
    for (int k = 0; k < FW / BL && k + off < cmd_log.size(); k++)
      chk_eq($sformatf("%s:cmd[%0d]", tag, k), cmd_log[k + off], base + 32'(4 * BL * k));
    chk_eq({tag, ":nwords"}, 32'(out_data.size()), FW);
    for (int i = 0; i < FW && i < out_data.size(); i++) begin
      chk_eq($sformatf("%s:data[%0d]", tag, i), out_data[i], base + 32'(4 * i));
      chk_eq($sformatf("%s:last[%0d]", tag, i), 32'(out_last[i]), 32'(i == FW - 1));
    end
    chk_eq({tag, ":latency"}, 32'(first_pop >= 0 && first_vld - first_pop >= 3), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit sel;
    int n;
    reset = 1'b1; mem_calib_done = 1'b0; p1_cmd_full = 1'b0; p1_rd_empty = 1'b1;
    p1_rd_data = '0; frame_start = 1'b0; buffer_sel = 1'b0; pix_ready = 1'b0;
    pops = 0; first_pop = -1; first_vld = -1;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst:cmd_en", 32'(p1_cmd_en), 0);
    chk_eq("rst:instr", 32'(p1_cmd_instr), 1);
    chk_eq("rst:bl", 32'(p1_cmd_bl), BL - 1);
    chk_eq("rst:addr", {2'b00, p1_cmd_byte_addr}, 0);
    chk_eq("rst:rd_en", 32'(p1_rd_en), 0);
    chk_eq("rst:pix_valid", 32'(pix_valid), 0);
    chk_eq("rst:pix_last", 32'(pix_last), 0);
    chk_eq("rst:busy", 32'(frame_busy), 0);
    chk_eq("rst:underrun", 32'(underrun), 0);
    reset = 1'b0;
    repeat (2) tick();

    // calibration gating
    start_frame(1'b0);
    repeat (10) tick();
    chk_eq("calib:no_cmd", 32'(cmd_log.size()), 0);
    chk_eq("calib:not_busy", 32'(frame_busy), 0);
    mem_calib_done = 1'b1;
    repeat (3) tick();
    pix_ready = 1'b1;
    start_frame(1'b0);
    run_until_idle("calib");
    check_frame("calib", B0, 0);

    // full frame from buffer 1
    start_frame(1'b1);
    run_until_idle("buf1");
    check_frame("buf1", B1, 0);

    // backpressure: FIFO fills, stream resumes intact
    pix_ready = 1'b0;
    start_frame(1'b0);
    repeat (40) tick();
    chk_eq("bp:ncmd", 32'(cmd_log.size()), 2);
    chk_eq("bp:no_out", 32'(out_data.size()), 0);
    chk_eq("bp:valid", 32'(pix_valid), 1);
    chk_eq("bp:underrun", 32'(underrun), 0);
    run_until_idle("bp");
    check_frame("bp", B0, 0);

    // command FIFO full holds off the command
    p1_cmd_full = 1'b1;
    start_frame(1'b1);
    repeat (10) tick();
    chk_eq("cfull:held", 32'(cmd_log.size()), 0);
    p1_cmd_full = 1'b0;
    tick();
    chk_eq("cfull:issued", 32'(cmd_log.size()), 1);
    run_until_idle("cfull");
    check_frame("cfull", B1, 0);

    // restart mid-burst
    dly1 = 1; dly2 = 1;
    pix_ready = 1'b0;
    start_frame(1'b1);
    n = 0;
    while (pops == 0 && n < 100) begin tick(); n++; end
    chk_eq("rs:first_pop", 32'(pops > 0), 1);
    pulse_start(1'b0);
    n = 0;
    while (cmd_log.size() < 2 && n < 100) begin tick(); n++; end
    chk_eq("rs:old_burst_popped", 32'(pops), BL);
    chk_eq("rs:no_out", 32'(out_data.size()), 0);
    if (cmd_log.size() > 0) chk_eq("rs:cmd0", cmd_log[0], B1);
    run_until_idle("rs");
    check_frame("rs", B0, 1);

    // randomized frames
    rnd = 1'b1;
    repeat (6) begin
      sel = 1'($urandom_range(0, 1));
      start_frame(sel);
      run_until_idle("rand");
      check_frame("rand", sel ? B1 : B0, 0);
    end
    rnd = 1'b0;

    // underrun: second burst arrives late
    dly1 = 0; dly2 = 20;
    pix_ready = 1'b1;
    start_frame(1'b1);
    run_until_idle("ur");
    check_frame("ur", B1, 0);
    chk_eq("ur:set", 32'(underrun), 1);
    repeat (5) tick();
    chk_eq("ur:sticky", 32'(underrun), 1);
    dly2 = 0;
    start_frame(1'b0);
    chk_eq("ur:cleared", 32'(underrun), 0);
    run_until_idle("ur2");
    check_frame("ur2", B0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
